// File: rtl/vga_score_keeper.sv
// vga_score_keeper: saturating eat counter with session high score and frame-synchronous display latch
// Ports:
//   i_clk          system clock (shared with VGA timing)
//   i_reset_n      asynchronous active-low reset
//   i_eat          eat level; each rising edge is one event
//   i_game_over    game over request (level or pulse)
//   i_restart      new game request (level or pulse)
//   i_frame_start  one-cycle pulse at start of vertical blanking
//   o_score        frame-latched displayed value
//   o_high_score   session high score
//   o_showing_high o_score currently shows the high score
//   o_playing      state is PLAYING
module vga_score_keeper #(
  parameter int MAX_SCORE    = 999,
  parameter int POINTS       = 1,
  parameter int BLINK_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_eat,
  input  logic       i_game_over,
  input  logic       i_restart,
  input  logic       i_frame_start,
  output logic [9:0] o_score,
  output logic [9:0] o_high_score,
  output logic       o_showing_high,
  output logic       o_playing
);
  typedef enum logic [1:0] {S_PLAYING, S_COMMIT, S_OVER} state_t;
  state_t      r_state;
  logic [9:0]  r_live;
  logic        r_eat_q;
  logic [7:0]  r_frame_cnt;
  logic        r_phase;
  logic        w_eat_rise;
  logic [10:0] w_sum;
  logic [9:0]  w_next_live;
  logic        w_show_high;
  // 11-bit sum so the ceiling clamp sees the carry and never wraps
  assign w_eat_rise  = i_eat & ~r_eat_q;
  assign w_sum       = {1'b0, r_live} + 11'(POINTS);
  assign w_next_live = (w_sum > 11'(MAX_SCORE)) ? 10'(MAX_SCORE) : w_sum[9:0];
  assign w_show_high = (r_state == S_OVER) && r_phase;
  assign o_playing   = (r_state == S_PLAYING);
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_PLAYING;
      r_live         <= '0;
      r_eat_q        <= 1'b0;
      r_frame_cnt    <= '0;
      r_phase        <= 1'b0;
      o_score        <= '0;
      o_high_score   <= '0;
      o_showing_high <= 1'b0;
    end else begin
      r_eat_q <= i_eat;
      // display only changes at vertical blanking, using pre-edge values
      if (i_frame_start) begin
        o_score        <= w_show_high ? o_high_score : r_live;
        o_showing_high <= w_show_high;
      end
      // restart wins over everything; a coincident eat edge is discarded
      if (i_restart) begin
        r_state     <= S_PLAYING;
        r_live      <= '0;
        r_frame_cnt <= '0;
        r_phase     <= 1'b0;
      end else begin
        case (r_state)
          S_PLAYING: begin
            if (w_eat_rise) r_live <= w_next_live;
            if (i_game_over) r_state <= S_COMMIT;
          end
          S_COMMIT: begin
            if (r_live > o_high_score) o_high_score <= r_live;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
            r_state     <= S_OVER;
          end
          S_OVER: begin
            if (i_frame_start) begin
              if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end
          default: r_state <= S_PLAYING;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_score_keeper.sv
// tb_vga_score_keeper: directed self-checking bench for vga_score_keeper
module tb_vga_score_keeper;
  logic       clk = 1'b0;
  logic       reset_n, eat, game_over, restart, frame_start;
  logic [9:0] score, high_score;
  logic       showing_high, playing;
  int         n_tests = 0;
  int         n_fail  = 0;

  vga_score_keeper #(.MAX_SCORE(999), .POINTS(1), .BLINK_FRAMES(2)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_eat(eat), .i_game_over(game_over),
    .i_restart(restart), .i_frame_start(frame_start), .o_score(score),
    .o_high_score(high_score), .o_showing_high(showing_high), .o_playing(playing)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_eat();
    eat = 1'b1; cyc(1); eat = 1'b0; cyc(1);
  endtask

  task automatic frame();
    frame_start = 1'b1; cyc(1); frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cyc(2); reset_n = 1'b1; cyc(1);
  endtask

  initial begin
    reset_n = 1'b0; eat = 1'b0; game_over = 1'b0; restart = 1'b0; frame_start = 1'b0;
    cyc(2);
    chk("rst_score", score, 10'd0);
    chk("rst_high", high_score, 10'd0);
    chk("rst_show", {9'd0, showing_high}, 10'd0);
    chk("rst_play", {9'd0, playing}, 10'd1);
    reset_n = 1'b1; cyc(1);

    // three short eat pulses, display only moves on frame_start
    for (int i = 0; i < 3; i++) begin
      eat = 1'b1; cyc(1); eat = 1'b0; cyc(4);
    end
    chk("t1_pre_frame", score, 10'd0);
    frame();
    chk("t1_score", score, 10'd3);
    chk("t1_show", {9'd0, showing_high}, 10'd0);
    chk("t1_play", {9'd0, playing}, 10'd1);

    // held eat counts once
    do_reset();
    for (int i = 0; i < 100; i++) begin
      eat = 1'b1; frame_start = (i % 20 == 10); cyc(1);
    end
    eat = 1'b0; frame_start = 1'b0;
    frame();
    chk("t2_held", score, 10'd1);

    // saturation at 999
    do_reset();
    for (int i = 0; i < 998; i++) pulse_eat();
    frame();
    chk("t3_998", score, 10'd998);
    for (int i = 0; i < 7; i++) pulse_eat();
    frame();
    chk("t3_sat", score, 10'd999);

    // eat and game_over together, then blink with BLINK_FRAMES=2
    do_reset();
    for (int i = 0; i < 7; i++) pulse_eat();
    eat = 1'b1; game_over = 1'b1; cyc(1); eat = 1'b0; game_over = 1'b0;
    chk("t4_play", {9'd0, playing}, 10'd0);
    chk("t4_high_k", high_score, 10'd0);
    cyc(1);
    chk("t4_high_k1", high_score, 10'd8);
    frame(); chk("t4_s1", score, 10'd8); chk("t4_h1", {9'd0, showing_high}, 10'd0); cyc(1);
    frame(); chk("t4_s2", score, 10'd8); chk("t4_h2", {9'd0, showing_high}, 10'd0); cyc(1);
    frame(); chk("t4_s3", score, 10'd8); chk("t4_h3", {9'd0, showing_high}, 10'd1); cyc(1);
    frame(); chk("t4_s4", score, 10'd8); chk("t4_h4", {9'd0, showing_high}, 10'd1); cyc(1);

    // restart discards coincident eat edge; lower score keeps high
    restart = 1'b1; eat = 1'b1; cyc(1); restart = 1'b0; eat = 1'b0;
    chk("t5_play", {9'd0, playing}, 10'd1);
    cyc(1);
    pulse_eat(); pulse_eat();
    game_over = 1'b1; cyc(1); game_over = 1'b0; cyc(2);
    chk("t5_high", high_score, 10'd8);
    frame();
    chk("t5_score", score, 10'd2);
    chk("t5_show", {9'd0, showing_high}, 10'd0);

    // async reset mid-game clears everything including high score
    restart = 1'b1; cyc(1); restart = 1'b0; cyc(1);
    for (int i = 0; i < 5; i++) pulse_eat();
    frame();
    chk("t6_score", score, 10'd5);
    chk("t6_high_pre", high_score, 10'd8);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_score", score, 10'd0);
    chk("t6_rst_high", high_score, 10'd0);
    chk("t6_rst_play", {9'd0, playing}, 10'd1);
    cyc(1); reset_n = 1'b1; cyc(1);
    frame();
    chk("t6_live_clr", score, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
